// File: rtl/c5_bus_responder.sv
// c5_bus_responder: memory-side responder for the c5 CPU bus.
// Holds a word-addressed synchronous RAM, a GPIO output register, a
// synchronized GPIO input and an optional timer/compare interrupt block.
// Optional feature macro: C5_BUS_TIMER_EN builds the timer, compare register
// and sticky interrupt; without it TIMER/COMPARE read 0 and O_intr is 0.
//
// Bus handshake: the CPU presents an access on I_address/I_byte_we/I_data_w
// every cycle. The access completes in a cycle where O_mem_pause is low; while
// O_mem_pause is high the CPU holds every bus input stable and nothing commits.
module c5_bus_responder #(
    parameter int RAM_AW      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        I_clk,
    input  logic        I_rst_n,
    input  logic [31:2] I_address_next,
    input  logic [3:0]  I_byte_we_next,
    input  logic [31:2] I_address,
    input  logic [3:0]  I_byte_we,
    input  logic [31:0] I_data_w,
    input  logic [31:0] I_gpio,
    output logic [31:0] O_data_r,
    output logic        O_mem_pause,
    output logic [31:0] O_gpio,
    output logic        O_led,
    output logic        O_intr,
    output logic [1:0]  O_dbg_state
);

    // Register map as word addresses (byte address >> 2)
    localparam logic [29:0] GPIO_OUT_A = 30'h0800_0000;
    localparam logic [29:0] GPIO_IN_A  = 30'h0800_0001;
    localparam logic [29:0] TIMER_A    = 30'h0800_0002;
    localparam logic [29:0] COMPARE_A  = 30'h0800_0003;

    localparam int          RAM_WORDS = 1 << RAM_AW;
    localparam bit          HAS_WAIT  = (WAIT_STATES > 0);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    logic        ram_sel;
    logic        pause;
    logic        commit;
    logic        wr_any;
    logic        ram_we;
    logic        bypass;
    logic [RAM_AW-1:0] wr_idx;
    logic [RAM_AW-1:0] rd_idx;

    logic [31:0] ram [0:RAM_WORDS-1];
    logic [31:0] ram_q;

    logic [31:0] gpio_q;
    logic [31:0] gin_s1, gin_s2;
    logic [31:0] timer_rd, cmp_rd;
    logic [31:0] reg_rd;

    // Only the RAM index bits of the pre-address are needed; the next byte
    // enables are part of the bus but carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{I_byte_we_next, I_address_next[31:RAM_AW+2]};

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  lanes);
        logic [31:0] res;
        res = old_w;
        for (int k = 0; k < 4; k++) begin
            if (lanes[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

    // Address decode and commit qualifiers; reset blocks every commit so a
    // write that was waiting when reset arrived is dropped.
    assign ram_sel = (I_address[31:28] == 4'd0);
    assign wr_idx  = I_address[RAM_AW+1:2];
    assign rd_idx  = I_address_next[RAM_AW+1:2];
    assign commit  = I_rst_n && !pause;
    assign wr_any  = commit && (I_byte_we != 4'b0000);
    assign ram_we  = wr_any && ram_sel;
    assign bypass  = ram_we && (wr_idx == rd_idx);

    // ---------------------------------------------------------------
    // Wait-state FSM
    // ---------------------------------------------------------------

    // State register: FSM state and remaining wait count
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: RAM accesses walk IDLE -> WAIT* -> DONE -> IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ram_sel && HAS_WAIT) begin
                    cnt_d   = WS - 4'd1;
                    state_d = (WS == 4'd1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: pause during the first cycle of a RAM access and all WAIT
    // cycles; reset forces it low immediately.
    always_comb begin
        pause = 1'b0;
        if (I_rst_n) begin
            case (state_q)
                ST_IDLE: pause = ram_sel && HAS_WAIT;
                ST_WAIT: pause = 1'b1;
                default: pause = 1'b0;
            endcase
        end
    end

    assign O_mem_pause = pause;
    assign O_dbg_state = state_q;

    // ---------------------------------------------------------------
    // RAM
    // ---------------------------------------------------------------

    // RAM write port: byte lanes commit only on a completing cycle
    always_ff @(posedge I_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ram_we && I_byte_we[k]) ram[wr_idx][8*k +: 8] <= I_data_w[8*k +: 8];
        end
    end

    // RAM read port: pre-addressed read with same-edge write bypass
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            ram_q <= 32'd0;
        end else if (commit) begin
            ram_q <= lane_merge(ram[rd_idx], I_data_w, bypass ? I_byte_we : 4'b0000);
        end
    end

    // ---------------------------------------------------------------
    // GPIO
    // ---------------------------------------------------------------

    // GPIO output register with per-lane writes
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            gpio_q <= 32'd0;
        end else if (wr_any && (I_address == GPIO_OUT_A)) begin
            gpio_q <= lane_merge(gpio_q, I_data_w, I_byte_we);
        end
    end

    // Two-flop synchronizer for the asynchronous GPIO inputs
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            gin_s1 <= 32'd0;
            gin_s2 <= 32'd0;
        end else begin
            gin_s1 <= I_gpio;
            gin_s2 <= gin_s1;
        end
    end

    assign O_gpio = gpio_q;
    assign O_led  = gpio_q[0];

    // ---------------------------------------------------------------
    // Timer / compare
    // ---------------------------------------------------------------
`ifdef C5_BUS_TIMER_EN
    logic [31:0] timer_q;
    logic [31:0] cmp_q;
    logic        intr_q;
    logic        cmp_wr;

    assign cmp_wr = wr_any && (I_address == COMPARE_A);

    // Free-running timer, compare register and sticky interrupt; a compare
    // write clears the interrupt even if a match happens on the same edge.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            timer_q <= 32'd0;
            cmp_q   <= 32'hFFFF_FFFF;
            intr_q  <= 1'b0;
        end else begin
            timer_q <= timer_q + 32'd1;
            if (cmp_wr) begin
                cmp_q  <= lane_merge(cmp_q, I_data_w, I_byte_we);
                intr_q <= 1'b0;
            end else if (timer_q == cmp_q) begin
                intr_q <= 1'b1;
            end
        end
    end

    assign timer_rd = timer_q;
    assign cmp_rd   = cmp_q;
    assign O_intr   = intr_q;
`else
    assign timer_rd = 32'd0;
    assign cmp_rd   = 32'd0;
    assign O_intr   = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Read data
    // ---------------------------------------------------------------

    // Combinational register read of the current address
    always_comb begin
        reg_rd = 32'd0;
        case (I_address)
            GPIO_OUT_A: reg_rd = gpio_q;
            GPIO_IN_A:  reg_rd = gin_s2;
            TIMER_A:    reg_rd = timer_rd;
            COMPARE_A:  reg_rd = cmp_rd;
            default:    reg_rd = 32'd0;
        endcase
    end

    assign O_data_r = ram_sel ? ram_q : reg_rd;

endmodule

// File: tb/tb_c5_bus_responder.sv
// Testbench for c5_bus_responder: a zero-wait instance (dut0) exercises RAM,
// GPIO and timer; a three-wait instance (dut3) exercises pausing and reset
// during a wait. A bench-side model is checked every cycle; directed literal
// checks pin the model.
module tb_c5_bus_responder;

  localparam int RAM_AW = 10;
  localparam int DEPTH  = 1 << RAM_AW;

  localparam logic [31:0] GPIO_OUT_A = 32'h2000_0000;
  localparam logic [31:0] GPIO_IN_A  = 32'h2000_0004;
  localparam logic [31:0] TIMER_A    = 32'h2000_0008;
  localparam logic [31:0] COMPARE_A  = 32'h2000_000C;
  localparam logic [31:0] UNMAP_A    = 32'h3000_0000;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  logic rst0_n, rst3_n;
  logic [31:0] a0, a0n, d0, a3, a3n, d3, gpio_in;
  logic [3:0] we0, we3;
  logic [31:0] data0, gpio0, data3, gpio3;
  logic pause0, led0, intr0, pause3, led3, intr3;
  logic [1:0] dbg0, dbg3;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  c5_bus_responder #(.RAM_AW(RAM_AW), .WAIT_STATES(0)) dut0 (
    .I_clk(clk), .I_rst_n(rst0_n),
    .I_address_next(a0n[31:2]), .I_byte_we_next(4'b0000),
    .I_address(a0[31:2]), .I_byte_we(we0), .I_data_w(d0), .I_gpio(gpio_in),
    .O_data_r(data0), .O_mem_pause(pause0), .O_gpio(gpio0), .O_led(led0),
    .O_intr(intr0), .O_dbg_state(dbg0)
  );

  c5_bus_responder #(.RAM_AW(RAM_AW), .WAIT_STATES(3)) dut3 (
    .I_clk(clk), .I_rst_n(rst3_n),
    .I_address_next(a3n[31:2]), .I_byte_we_next(4'b0000),
    .I_address(a3[31:2]), .I_byte_we(we3), .I_data_w(d3), .I_gpio(32'd0),
    .O_data_r(data3), .O_mem_pause(pause3), .O_gpio(gpio3), .O_led(led3),
    .O_intr(intr3), .O_dbg_state(dbg3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_ram(input logic [31:0] a);
    return a < 32'h1000_0000;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = o;
    for (int k = 0; k < 4; k++) if (we[k]) r[8*k +: 8] = n[8*k +: 8];
    return r;
  endfunction

  // dut0 model state
  logic [31:0] mem0 [DEPTH];
  bit          mv0 [DEPTH];
  bit          ld0_kind;
  int          ld0_idx;
  logic [31:0] gp_m, gin1_m, gin2_m, tmr_m, cmp_m;
  logic        intr_m;

  // dut3 model state
  logic [31:0] mem3 [DEPTH];
  bit          mv3 [DEPTH];
  bit          ld3_kind;
  int          ld3_idx;
  int          pc3;
  logic        exp_p3;

  // Every RAM access on dut3 pauses for exactly 3 cycles before completing
  assign exp_p3 = rst3_n && is_ram(a3) && (pc3 < 3);

  function automatic logic [31:0] exp_reg0(input logic [31:0] a);
    case (a)
      GPIO_OUT_A: return gp_m;
      GPIO_IN_A:  return gin2_m;
`ifdef C5_BUS_TIMER_EN
      TIMER_A:    return tmr_m;
      COMPARE_A:  return cmp_m;
`endif
      default:    return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst0_n) begin
    if (!rst0_n) begin
      ld0_kind <= 1'b0;
      gp_m <= 32'd0; gin1_m <= 32'd0; gin2_m <= 32'd0;
      tmr_m <= 32'd0; cmp_m <= 32'hFFFF_FFFF; intr_m <= 1'b0;
    end else begin
      gin1_m <= gpio_in;
      gin2_m <= gin1_m;
      ld0_kind <= 1'b1;
      ld0_idx <= widx(a0n);
      if (we0 != 4'd0) begin
        if (is_ram(a0)) begin
          mem0[widx(a0)] <= merge(mem0[widx(a0)], d0, we0);
          if (we0 == 4'hF) mv0[widx(a0)] <= 1'b1;
        end
        if (a0 == GPIO_OUT_A) gp_m <= merge(gp_m, d0, we0);
      end
`ifdef C5_BUS_TIMER_EN
      tmr_m <= tmr_m + 32'd1;
      if (we0 != 4'd0 && a0 == COMPARE_A) begin
        cmp_m <= merge(cmp_m, d0, we0);
        intr_m <= 1'b0;
      end else if (tmr_m == cmp_m) begin
        intr_m <= 1'b1;
      end
`endif
    end
  end

  always @(posedge clk or negedge rst3_n) begin
    if (!rst3_n) begin
      pc3 <= 0;
      ld3_kind <= 1'b0;
    end else begin
      pc3 <= exp_p3 ? pc3 + 1 : 0;
      if (!exp_p3) begin
        ld3_kind <= 1'b1;
        ld3_idx <= widx(a3n);
        if (we3 != 4'd0 && is_ram(a3)) begin
          mem3[widx(a3)] <= merge(mem3[widx(a3)], d3, we3);
          if (we3 == 4'hF) mv3[widx(a3)] <= 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pause0", pause0, 1'b0);
      chk("gpio0", gpio0, gp_m);
      chk("led0", led0, gp_m[0]);
      chk("intr0", intr0, intr_m);
      if (is_ram(a0)) begin
        if (!ld0_kind) chk("ramq0_rst", data0, 32'd0);
        else if (ld0_idx == widx(a0) && mv0[ld0_idx]) chk("ram_rd0", data0, mem0[ld0_idx]);
      end else begin
        chk("reg_rd0", data0, exp_reg0(a0));
      end
      chk("pause3", pause3, exp_p3);
      chk("gpio3", gpio3, 32'd0);
      chk("led3", led3, 1'b0);
      chk("intr3", intr3, 1'b0);
      if (is_ram(a3)) begin
        if (!ld3_kind) chk("ramq3_rst", data3, 32'd0);
        else if (ld3_idx == widx(a3) && mv3[ld3_idx]) chk("ram_rd3", data3, mem3[ld3_idx]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc0(input logic [31:0] nxt, input logic [31:0] adr,
                      input logic [3:0] we, input logic [31:0] dat);
    @(posedge clk); #1;
    a0n = nxt; a0 = adr; we0 = we; d0 = dat;
  endtask

  // Presents one access to dut3, holds it while paused, returns the number of
  // paused cycles; ends on the falling edge of the completing cycle.
  task automatic access3(input logic [31:0] nxt, input logic [31:0] adr,
                         input logic [3:0] we, input logic [31:0] dat, output int np);
    @(posedge clk); #1;
    a3n = nxt; a3 = adr; we3 = we; d3 = dat;
    np = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pause3 === 1'b0) break;
      np++;
      @(posedge clk); #1;
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int np;
    bit found;
    rst0_n = 1'b0; rst3_n = 1'b0;
    a0 = 32'd0; a0n = 32'd0; d0 = 32'd0; we0 = 4'd0;
    a3 = GPIO_OUT_A; a3n = GPIO_OUT_A; d3 = 32'd0; we3 = 4'd0;
    gpio_in = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_data", data0, 32'd0);
    chk("rst_pause", pause0, 1'b0);
    chk("rst_gpio", gpio0, 32'd0);
    chk("rst_led", led0, 1'b0);
    chk("rst_intr", intr0, 1'b0);
    rst0_n = 1'b1; rst3_n = 1'b1;

    // Reset value of COMPARE
    cyc0(UNMAP_A, COMPARE_A, 4'h0, 32'd0);
    @(negedge clk);
`ifdef C5_BUS_TIMER_EN
    chk("id_cmp", data0, 32'hFFFF_FFFF);
`else
    chk("id_cmp", data0, 32'd0);
`endif

    // Timer: COMPARE=20
    cyc0(UNMAP_A, COMPARE_A, 4'hF, 32'd20);
`ifdef C5_BUS_TIMER_EN
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cyc0(UNMAP_A, TIMER_A, 4'h0, 32'd0);
      @(negedge clk);
      if (data0 == 32'd20) found = 1'b1;
    end
    chk("tmr_reach20", found, 1'b1);
    chk("intr_pre", intr0, 1'b0);
    cyc0(UNMAP_A, TIMER_A, 4'h0, 32'd0);
    @(negedge clk);
    chk("intr_set", intr0, 1'b1);
    chk("tmr_21", data0, 32'd21);
`else
    cyc0(UNMAP_A, COMPARE_A, 4'h0, 32'd0);
    @(negedge clk);
    chk("cmp_nowr", data0, 32'd0);
    chk("intr_off", intr0, 1'b0);
    cyc0(UNMAP_A, TIMER_A, 4'h0, 32'd0);
    @(negedge clk);
    chk("tmr_off", data0, 32'd0);
`endif

    // RAM write/read with no wait states
    cyc0(32'h10, UNMAP_A, 4'h0, 32'd0);
    cyc0(32'h10, 32'h10, 4'hF, 32'hDEAD_BEEF);
    cyc0(32'h10, 32'h10, 4'h1, 32'h0000_00AA);
    @(negedge clk);
    chk("wr_full", data0, 32'hDEAD_BEEF);
    cyc0(32'h20, 32'h10, 4'h0, 32'd0);
    @(negedge clk);
    chk("wr_lane0", data0, 32'hDEAD_BEAA);

    // Bypass: write word 8 while pre-addressing word 8
    cyc0(32'h20, 32'h20, 4'hF, 32'h1234_5678);
    cyc0(32'h1010, 32'h20, 4'h0, 32'd0);
    @(negedge clk);
    chk("bypass", data0, 32'h1234_5678);
    // Alias: byte 0x1010 is word 0x404, wraps to word 4
    cyc0(UNMAP_A, 32'h1010, 4'h0, 32'd0);
    @(negedge clk);
    chk("alias", data0, 32'hDEAD_BEAA);
    cyc0(UNMAP_A, UNMAP_A, 4'hF, 32'h5555_5555);
    @(negedge clk);
    chk("unmapped", data0, 32'd0);

    // GPIO out
    cyc0(UNMAP_A, GPIO_OUT_A, 4'hF, 32'h0000_0001);
    cyc0(UNMAP_A, GPIO_OUT_A, 4'h0, 32'd0);
    @(negedge clk);
    chk("led", led0, 1'b1);
    chk("gpio", gpio0, 32'h0000_0001);
    chk("gpio_rd", data0, 32'h0000_0001);
    cyc0(UNMAP_A, GPIO_OUT_A, 4'b0100, 32'h00AB_0000);

    // GPIO in: two-cycle synchronizer lag
    cyc0(UNMAP_A, GPIO_IN_A, 4'h0, 32'd0);
    gpio_in = 32'hA5A5_0000;
    @(negedge clk);
    chk("gpio_lane", gpio0, 32'h00AB_0001);
    chk("gin_c1", data0, 32'd0);
    cyc0(UNMAP_A, GPIO_IN_A, 4'h0, 32'd0);
    @(negedge clk);
    chk("gin_c2", data0, 32'd0);
    cyc0(UNMAP_A, GPIO_IN_A, 4'h0, 32'd0);
    @(negedge clk);
    chk("gin_c3", data0, 32'hA5A5_0000);

`ifdef C5_BUS_TIMER_EN
    // Compare write clears the sticky interrupt
    chk("intr_hold", intr0, 1'b1);
    cyc0(UNMAP_A, COMPARE_A, 4'hF, 32'hFFFF_FFFF);
    @(negedge clk);
    chk("intr_hold2", intr0, 1'b1);
    cyc0(UNMAP_A, COMPARE_A, 4'h0, 32'd0);
    @(negedge clk);
    chk("intr_clr", intr0, 1'b0);
    chk("cmp_rd", data0, 32'hFFFF_FFFF);
`endif

    // Wait states (dut3)
    access3(32'h40, GPIO_OUT_A, 4'h0, 32'd0, np);
    chk("w3_reg_np", np, 0);
    access3(32'h40, 32'h40, 4'hF, 32'hCAFE_F00D, np);
    chk("w3_wr_np", np, 3);
    access3(32'h44, 32'h40, 4'h0, 32'd0, np);
    chk("w3_rd_np", np, 3);
    chk("w3_rd", data3, 32'hCAFE_F00D);

    // Reset during the second pause cycle of a write
    @(posedge clk); #1;
    a3n = 32'h40; a3 = 32'h40; we3 = 4'hF; d3 = 32'h0BAD_BAD0;
    @(negedge clk);
    chk("mw_p1", pause3, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mw_p2", pause3, 1'b1);
    #2 rst3_n = 1'b0;
    #1 chk("mw_rst_pause", pause3, 1'b0);
    @(posedge clk); #1;
    a3n = 32'h40; a3 = GPIO_OUT_A; we3 = 4'h0; d3 = 32'd0;
    @(negedge clk);
    rst3_n = 1'b1;
    access3(32'h44, 32'h40, 4'h0, 32'd0, np);
    chk("mw_rd_np", np, 3);
    chk("mw_keep", data3, 32'hCAFE_F00D);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
